// File: rtl/apu_reg_pkg.sv
// rtl/apu_reg_pkg.sv - APU register bank address constants, DMG readback mask and channel address map
package apu_reg_pkg;

  localparam logic [7:0] WIN_LO = 8'h10;
  localparam logic [7:0] WIN_HI = 8'h3F;

  // Bits that read back as 1 on DMG; ch0 reg0 in the LSBs.
  localparam int DMG_REGS = 20;
  localparam logic [DMG_REGS*8-1:0] DMG_RD_OR_MASK = {
    8'hBF, 8'h00, 8'h00, 8'hFF, 8'hFF,
    8'hBF, 8'hFF, 8'h9F, 8'hFF, 8'h7F,
    8'hBF, 8'hFF, 8'h00, 8'h3F, 8'hFF,
    8'hBF, 8'hFF, 8'h00, 8'h3F, 8'h80
  };

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
    logic [7:0] r;
  } ch_map_t;

  function automatic ch_map_t map_ch_addr(input logic [7:0] lo, input logic [7:0] base,
                                          input int num_ch, input int regs);
    ch_map_t m;
    int      idx;
    m   = '0;
    idx = int'(lo) - int'(base);
    if (idx >= 0 && idx < num_ch * regs) begin
      m.hit = 1'b1;
      m.ch  = 8'(idx / regs);
      m.r   = 8'(idx % regs);
    end
    return m;
  endfunction

endpackage

// File: rtl/apu_reg_addr_dec.sv
// rtl/apu_reg_addr_dec.sv - combinational decode of the FF10-FF3F APU register window
module apu_reg_addr_dec
  import apu_reg_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         REGS_PER_CH = 5,
  parameter logic [7:0] CH_BASE     = 8'h10,
  parameter logic [7:0] CTRL_BASE   = 8'h24,
  parameter logic [7:0] WAVE_BASE   = 8'h30
) (
  input  logic [7:0] a,
  input  logic       ffxx,
  output logic       hit_ch,
  output logic [7:0] ch,
  output logic [7:0] r,
  output logic       hit_ctrl,
  output logic       hit_master,
  output logic       hit_wave,
  output logic       hit_unmapped
);

  ch_map_t cm;
  logic    in_win;

  // Channel space takes priority so an oversized channel map can never alias control or wave.
  always_comb begin
    cm           = map_ch_addr(a, CH_BASE, NUM_CH, REGS_PER_CH);
    in_win       = ffxx && (a >= WIN_LO) && (a <= WIN_HI);
    hit_ch       = in_win && cm.hit;
    ch           = cm.ch;
    r            = cm.r;
    hit_ctrl     = in_win && !cm.hit && ((a == CTRL_BASE) || (a == CTRL_BASE + 8'd1));
    hit_master   = in_win && !cm.hit && (a == CTRL_BASE + 8'd2);
    hit_wave     = in_win && !cm.hit && (a >= WAVE_BASE) && (a <= WAVE_BASE + 8'd15);
    hit_unmapped = in_win && !(cm.hit || hit_ctrl || hit_master || hit_wave);
  end

endmodule

// File: rtl/apu_reg_bank.sv
// rtl/apu_reg_bank.sv - APU register storage, write edge detect, trigger/length pulses and readback
module apu_reg_bank
  import apu_reg_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter int         REGS_PER_CH = 5,
  parameter logic [7:0] CH_BASE     = 8'h10,
  parameter logic [7:0] CTRL_BASE   = 8'h24,
  parameter logic [7:0] WAVE_BASE   = 8'h30,
  parameter logic [NUM_CH*REGS_PER_CH*8-1:0] RD_OR_MASK = DMG_RD_OR_MASK[NUM_CH*REGS_PER_CH*8-1:0]
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [15:0]                     a,
  input  logic [7:0]                      d,
  input  logic                            cpu_wr,
  input  logic                            cpu_rd,
  input  logic                            ffxx,
  output logic [7:0]                      q,
  output logic                            q_oe,
  input  logic [NUM_CH-1:0]               ch_active,
  input  logic                            wave_busy,
  input  logic [3:0]                      wave_rd_addr,
  output logic [7:0]                      wave_rd_data,
  output logic [NUM_CH*REGS_PER_CH*8-1:0] ch_regs,
  output logic [15:0]                     ctrl_regs,
  output logic                            power_on,
  output logic [NUM_CH-1:0]               trig,
  output logic [NUM_CH-1:0]               len_load
);

  localparam int NREG  = NUM_CH * REGS_PER_CH;
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic             page_ff;
  logic             hit_ch, hit_ctrl, hit_master, hit_wave, hit_unmapped, rd_hit;
  logic [7:0]       dec_ch, dec_r;
  logic [IDX_W-1:0] ch_idx;
  logic [3:0]       wave_idx;
  logic             wr_q, wr_commit;
  logic             we_ch, we_ctrl, we_master, we_wave;
  logic [7:0]       ch_mem   [NREG];
  logic [7:0]       mask_arr [NREG];
  logic [7:0]       wave_mem [16];
  logic [7:0]       vol, pan;
  logic [3:0]       act4;
  logic [7:0]       rd_data;
  logic [NUM_CH-1:0] trig_n, len_n;

  // ffxx comes from the bus, but the page is confirmed against the address as well.
  assign page_ff = ffxx && (a[15:8] == 8'hFF);

  apu_reg_addr_dec #(
    .NUM_CH      (NUM_CH),
    .REGS_PER_CH (REGS_PER_CH),
    .CH_BASE     (CH_BASE),
    .CTRL_BASE   (CTRL_BASE),
    .WAVE_BASE   (WAVE_BASE)
  ) u_dec (
    .a            (a[7:0]),
    .ffxx         (page_ff),
    .hit_ch       (hit_ch),
    .ch           (dec_ch),
    .r            (dec_r),
    .hit_ctrl     (hit_ctrl),
    .hit_master   (hit_master),
    .hit_wave     (hit_wave),
    .hit_unmapped (hit_unmapped)
  );

  assign ch_idx    = IDX_W'(int'(dec_ch) * REGS_PER_CH + int'(dec_r));
  assign wave_idx  = a[3:0] - WAVE_BASE[3:0];
  assign rd_hit    = hit_ch | hit_ctrl | hit_master | hit_wave | hit_unmapped;

  // A held strobe commits only on its first cycle.
  assign wr_commit = cpu_wr && !wr_q;
  assign we_ch     = wr_commit && power_on && hit_ch;
  assign we_ctrl   = wr_commit && power_on && hit_ctrl;
  assign we_master = wr_commit && hit_master;
  assign we_wave   = wr_commit && hit_wave && !wave_busy;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign ch_regs[g*8 +: 8] = ch_mem[g];
    assign mask_arr[g]       = RD_OR_MASK[g*8 +: 8];
  end

  for (genvar g = 0; g < 4; g++) begin : g_act
    if (g < NUM_CH) begin : g_real
      assign act4[g] = ch_active[g];
    end else begin : g_absent
      assign act4[g] = 1'b1;
    end
  end

  assign ctrl_regs    = {pan, vol};
  assign wave_rd_data = wave_mem[wave_rd_addr];

  always_comb begin
    trig_n = '0;
    len_n  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (we_ch && (dec_ch == 8'(i))) begin
        trig_n[i] = (dec_r == 8'(REGS_PER_CH - 1)) && d[7];
        len_n[i]  = (dec_r == 8'd1);
      end
    end
  end

  always_comb begin
    rd_data = 8'hFF;
    if (hit_ch)
      rd_data = ch_mem[ch_idx] | mask_arr[ch_idx];
    else if (hit_ctrl)
      rd_data = (a[7:0] == CTRL_BASE) ? vol : pan;
    else if (hit_master)
      rd_data = {power_on, 3'b111, act4};
    else if (hit_wave && !wave_busy)
      rd_data = wave_mem[wave_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= 1'b0;
      power_on <= 1'b0;
      vol      <= '0;
      pan      <= '0;
      trig     <= '0;
      len_load <= '0;
      q        <= '0;
      q_oe     <= 1'b0;
      for (int i = 0; i < NREG; i++) ch_mem[i] <= '0;
      for (int i = 0; i < 16; i++) wave_mem[i] <= '0;
    end else begin
      wr_q     <= cpu_wr;
      trig     <= trig_n;
      len_load <= len_n;
      if (we_master) begin
        power_on <= d[7];
        // Powering down wipes channel and control state; wave RAM survives.
        if (power_on && !d[7]) begin
          vol <= '0;
          pan <= '0;
          for (int i = 0; i < NREG; i++) ch_mem[i] <= '0;
        end
      end
      if (we_ch) ch_mem[ch_idx] <= d;
      if (we_ctrl) begin
        if (a[7:0] == CTRL_BASE) vol <= d;
        else                     pan <= d;
      end
      if (we_wave) wave_mem[wave_idx] <= d;
      if (cpu_rd && rd_hit) begin
        q    <= rd_data;
        q_oe <= 1'b1;
      end else begin
        q_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_reg_bank.sv
// tb/tb_apu_reg_bank.sv - directed self-checking bench for apu_reg_bank (4-channel and 2-channel builds)
module tb_apu_reg_bank;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  a = '0;
  logic [7:0]   d = '0;
  logic         cpu_wr = 1'b0, cpu_rd = 1'b0, ffxx = 1'b0;
  logic [3:0]   ch_active = 4'b0000;
  logic         wave_busy = 1'b0;
  logic [3:0]   wave_rd_addr = '0;

  logic [7:0]   q, wave_rd_data;
  logic         q_oe, power_on;
  logic [159:0] ch_regs;
  logic [15:0]  ctrl_regs;
  logic [3:0]   trig, len_load;

  logic [7:0]   q2, wave_rd_data2;
  logic         q_oe2, power_on2;
  logic [79:0]  ch_regs2;
  logic [15:0]  ctrl_regs2;
  logic [1:0]   trig2, len_load2;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  apu_reg_bank u4 (
    .clk(clk), .reset(reset), .a(a), .d(d), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .ffxx(ffxx),
    .q(q), .q_oe(q_oe), .ch_active(ch_active), .wave_busy(wave_busy),
    .wave_rd_addr(wave_rd_addr), .wave_rd_data(wave_rd_data), .ch_regs(ch_regs),
    .ctrl_regs(ctrl_regs), .power_on(power_on), .trig(trig), .len_load(len_load)
  );

  apu_reg_bank #(.NUM_CH(2), .REGS_PER_CH(5)) u2 (
    .clk(clk), .reset(reset), .a(a), .d(d), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .ffxx(ffxx),
    .q(q2), .q_oe(q_oe2), .ch_active(ch_active[1:0]), .wave_busy(wave_busy),
    .wave_rd_addr(wave_rd_addr), .wave_rd_data(wave_rd_data2), .ch_regs(ch_regs2),
    .ctrl_regs(ctrl_regs2), .power_on(power_on2), .trig(trig2), .len_load(len_load2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    a = addr; ffxx = (addr[15:8] == 8'hFF); d = data; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] addr);
    @(negedge clk);
    a = addr; ffxx = (addr[15:8] == 8'hFF); cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_q", q, 8'h00);
    check("rst_q_oe", q_oe, 0);
    check("rst_power", power_on, 0);
    check("rst_trig", trig, 0);
    check("rst_len", len_load, 0);
    check("rst_ctrl", ctrl_regs, 0);
    check("rst_ch_lo", ch_regs[31:0], 0);
    reset = 1'b0;

    bus_rd(16'hFF26);
    check("master_off_rd", q, 8'h70);
    check("master_off_oe", q_oe, 1);
    @(negedge clk);
    check("oe_drop", q_oe, 0);
    check("q_hold", q, 8'h70);

    bus_wr(16'hFF12, 8'hF3);
    check("off_wr_ignored", ch_regs[23:16], 8'h00);
    bus_rd(16'hFF12);
    check("off_rd_ff12", q, 8'h00);

    bus_wr(16'hFF26, 8'h80);
    check("power_on", power_on, 1);
    bus_rd(16'hFF26);
    check("master_on_rd", q, 8'hF0);

    bus_wr(16'hFF14, 8'h87);
    check("trig0_pulse", trig, 4'b0001);
    check("len_none", len_load, 4'b0000);
    @(negedge clk);
    check("trig0_drop", trig, 4'b0000);
    check("ch0r4_val", ch_regs[39:32], 8'h87);
    bus_rd(16'hFF14);
    check("ff14_rd", q, 8'hBF);

    bus_wr(16'hFF11, 8'h40);
    check("len0_pulse", len_load, 4'b0001);
    check("trig_none", trig, 4'b0000);
    bus_rd(16'hFF11);
    check("ff11_rd", q, 8'h7F);

    // Held write: second-cycle data change must not land.
    @(negedge clk);
    a = 16'hFF19; ffxx = 1'b1; d = 8'h80; cpu_wr = 1'b1; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (trig[1]) pulses++;
      if (i == 0) d = 8'h81;
    end
    cpu_wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (trig[1]) pulses++;
    end
    check("held_pulses", pulses, 1);
    check("held_value", ch_regs[79:72], 8'h80);

    @(negedge clk);
    a = 16'hFF12; ffxx = 1'b1; d = 8'h5A; cpu_wr = 1'b1; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    check("rw_same_q", q, 8'h00);
    check("rw_same_commit", ch_regs[23:16], 8'h5A);

    bus_wr(16'hFF24, 8'h77);
    bus_wr(16'hFF25, 8'hF3);
    check("ctrl_val", ctrl_regs, 16'hF377);
    bus_rd(16'hFF25);
    check("ff25_rd", q, 8'hF3);
    bus_wr(16'hFF26, 8'h00);
    check("pwroff_ctrl", ctrl_regs, 16'h0000);
    check("pwroff_ch", ch_regs[79:0], 0);
    check("pwroff_power", power_on, 0);
    check("pwroff_trig", trig, 0);
    bus_wr(16'hFF14, 8'h87);
    check("off_trig", trig, 0);
    check("off_ch0r4", ch_regs[39:32], 8'h00);

    wave_busy = 1'b1; wave_rd_addr = 4'd0;
    bus_wr(16'hFF30, 8'hAB);
    check("wave_busy_drop", wave_rd_data, 8'h00);
    bus_rd(16'hFF30);
    check("wave_busy_rd", q, 8'hFF);
    wave_busy = 1'b0;
    bus_wr(16'hFF30, 8'hAB);
    check("wave_wr", wave_rd_data, 8'hAB);
    bus_rd(16'hFF30);
    check("wave_rd", q, 8'hAB);

    bus_rd(16'hFF40);
    check("oob_oe", q_oe, 0);
    check("oob_q", q, 8'hAB);
    bus_rd(16'hFF28);
    check("unmapped_rd", q, 8'hFF);

    bus_wr(16'hFF26, 8'h80);
    bus_wr(16'hFF1B, 8'h12);
    check("u2_ff1b_lo", ch_regs2[31:0], 0);
    check("u2_ff1b_mid", ch_regs2[63:32], 0);
    check("u2_ff1b_hi", ch_regs2[79:64], 0);
    check("u4_ff1b", ch_regs[95:88], 8'h12);
    bus_rd(16'hFF1B);
    check("u2_ff1b_rd", q2, 8'hFF);
    check("u2_ff1b_oe", q_oe2, 1);
    bus_rd(16'hFF26);
    check("u2_master_rd", q2, 8'hFC);
    check("u4_master_rd", q, 8'hF0);
    bus_wr(16'hFF19, 8'hC7);
    check("u2_trig1", trig2, 2'b10);
    check("u4_trig1", trig, 4'b0010);
    check("u2_ch1r4", ch_regs2[79:72], 8'hC7);

    // Reset in the middle of a held wave write.
    @(negedge clk);
    a = 16'hFF31; ffxx = 1'b1; d = 8'h3C; cpu_wr = 1'b1; wave_rd_addr = 4'd1;
    @(negedge clk);
    check("pre_rst_wave", wave_rd_data, 8'h3C);
    reset = 1'b1;
    #1;
    check("mid_rst_wave", wave_rd_data, 8'h00);
    check("mid_rst_power", power_on, 0);
    check("mid_rst_ch", ch_regs[95:64], 0);
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_trig", trig, 0);
    @(negedge clk);
    reset = 1'b0; d = 8'h5C;
    @(negedge clk);
    check("post_rst_commit", wave_rd_data, 8'h5C);
    d = 8'h66;
    repeat (2) @(negedge clk);
    check("post_rst_once", wave_rd_data, 8'h5C);
    cpu_wr = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
